// File: rtl/mul_sequencer.sv
//------------------------------------------------------------------------------
// mul_sequencer
//   Shift-add multiply sequencer for the EX stage. Holds the pipeline while a
//   mul iterates and returns the low WIDTH bits of the product with a done pulse.
//   Optional: MUL_EARLY_TERM_EN ends the run once the multiplier is exhausted.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       aluController,
    input  logic             flush,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] c_ALU_MUL = 2'b10;
    localparam int         c_CW      = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_result;
    logic [c_CW-1:0]   r_count;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic [WIDTH-1:0]  w_acc_step;
    logic              w_finish;

    assign w_accept   = (r_state == S_IDLE) && start && (aluController == c_ALU_MUL) && !flush;
    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MUL_EARLY_TERM_EN
    // Once every multiplier bit has been consumed the accumulator is final.
    assign w_finish = (r_mplier == '0);
`else
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    assign w_finish = (r_count == c_LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= srcA;
                        r_mplier <= srcB;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
`ifdef MUL_EARLY_TERM_EN
                        if (w_finish) begin
                            r_result <= r_acc;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_acc    <= w_acc_step;
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= r_mplier >> 1;
                            r_count  <= r_count + 1'b1;
                        end
`else
                        r_acc    <= w_acc_step;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 1'b1;
                        // The final step's sum goes straight into the result.
                        if (w_finish) begin
                            r_result <= w_acc_step;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`endif
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall  = w_accept | (r_state == S_RUN);
    assign busy   = r_busy;
    assign done   = r_done & ~flush;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
//------------------------------------------------------------------------------
// tb_mul_sequencer
//   Self-checking bench: table vectors, hand-written flush/reset sequences and
//   randomized multiplies against a plain-arithmetic product/latency model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   alu = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    mul_sequencer #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .aluController (alu),
        .flush         (flush),
        .srcA          (a),
        .srcB          (b),
        .stall         (stall),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   alu;
        logic [W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return p[W-1:0];
    endfunction

    // Cycles from the accepting cycle to the done pulse.
    function automatic int model_lat(input logic [W-1:0] y);
`ifdef MUL_EARLY_TERM_EN
        int hb = -1;
        for (int i = 0; i < W; i++) if (y[i]) hb = i;
        return (hb < 0) ? 2 : hb + 3;
`else
        return W + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] exp);
        int lat = model_lat(y);
        int bad_stall = 0;
        int bad_busy = 0;
        int done_at = -1;
        int extra_done = 0;
        start = 1'b1; alu = 2'b10; a = x; b = y; flush = 1'b0;
        #1;
        check("accept_stall", {31'b0, stall}, 1);
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk);
            #1;
            // A second start while the run is in flight must be ignored.
            if (k < lat && k <= 3) begin
                start = 1'b1; alu = 2'b10; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0; alu = 2'b00;
            end
            #1;
            if (stall !== (k < lat)) bad_stall++;
            if (busy !== (k <= lat)) bad_busy++;
            if (done === 1'b1) begin
                if (done_at < 0) done_at = k; else extra_done++;
            end
            if (k == lat) check("result_at_done", result, exp);
        end
        check("stall_window", bad_stall, 0);
        check("busy_window", bad_busy, 0);
        check("done_latency", done_at, lat);
        check("single_done", extra_done, 0);
        check("result_held", result, exp);
    endtask

    task automatic run_ignored(input logic [1:0] alu_v);
        logic [W-1:0] prev = result;
        int bad = 0;
        start = 1'b1; alu = alu_v; a = $urandom; b = $urandom; flush = 1'b0;
        #1;
        check("nonmul_stall", {31'b0, stall}, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        start = 1'b0; alu = 2'b00;
        check("nonmul_idle", bad, 0);
        check("nonmul_result", result, prev);
    endtask

    initial begin
        vec_t tbl[8];
        tbl = '{
            '{32'd7,          32'd6,          2'b10, 32'd42},
            '{32'hFFFFFFFF,   32'd2,          2'b10, 32'hFFFFFFFE},
            '{32'd5,          32'd3,          2'b10, 32'd15},
            '{32'd12345,      32'd0,          2'b10, 32'd0},
            '{32'hFFFFFFFF,   32'hFFFFFFFF,   2'b10, 32'd1},
            '{32'h80000000,   32'h80000001,   2'b10, 32'h80000000},
            '{32'd9,          32'd9,          2'b00, 32'd0},
            '{32'd3,          32'd4,          2'b11, 32'd0}
        };

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", {31'b0, stall}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        check("reset_result", result, 0);
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].alu == 2'b10) run_mul(tbl[i].a, tbl[i].b, tbl[i].exp);
            else run_ignored(tbl[i].alu);
            tick();
        end

        // Flush mid-run: no done, result keeps the previous product.
        run_mul(32'd7, 32'd6, 32'd42);
        tick();
        begin
            int bad = 0;
            start = 1'b1; alu = 2'b10; a = 32'd100; b = 32'd100;
            for (int k = 1; k <= 10; k++) begin
                tick();
                start = 1'b0; alu = 2'b00;
            end
            flush = 1'b1;
            #1;
            check("flush_cycle_stall", {31'b0, stall}, 1);
            tick();
            flush = 1'b0;
            check("flush_stall_drop", {31'b0, stall}, 0);
            check("flush_busy_drop", {31'b0, busy}, 0);
            for (int k = 0; k < 30; k++) begin
                if (done !== 1'b0 || busy !== 1'b0) bad++;
                tick();
            end
            check("flush_no_done", bad, 0);
            check("flush_result_kept", result, 32'd42);
        end

        // Flush in IDLE overrides start.
        start = 1'b1; alu = 2'b10; a = 32'd3; b = 32'd3; flush = 1'b1;
        #1;
        check("idle_flush_stall", {31'b0, stall}, 0);
        tick();
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", {31'b0, busy}, 0);
        tick();

        // Async reset mid-run.
        start = 1'b1; alu = 2'b10; a = 32'd11; b = 32'd13;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start = 1'b0; alu = 2'b00;
        end
        rst = 1'b0;
        #1;
        check("midrst_stall", {31'b0, stall}, 0);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_done", {31'b0, done}, 0);
        check("midrst_result", result, 0);
        tick();
        rst = 1'b1;
        tick();
        check("postrst_busy", {31'b0, busy}, 0);
        run_mul(32'd11, 32'd13, 32'd143);
        tick();

        // Randomized multiplies with varied multiplier magnitude.
        for (int n = 0; n < 10; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_mul(ra, rb, model_prod(ra, rb));
            tick();
            if (n % 3 == 0) begin
                logic [1:0] av;
                av = 2'($urandom_range(0, 2));
                if (av == 2'b10) av = 2'b11;
                run_ignored(av);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
